// File: rtl/axi_rd_slave.sv
// AXI4 read-channel slave backed by a word-addressed memory with a side write port.
// Optional AXI_RD_SLAVE_ERR_EN: beats past the end of memory return SLVERR with zero data.
module axi_rd_slave #(
    parameter int AWID_WIDTH   = 4,
    parameter int AWADDR_WIDTH = 32,
    parameter int WDATA_WIDTH  = 64,
    parameter int MEM_DEPTH    = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [AWID_WIDTH-1:0]        ARID,
    input  logic [AWADDR_WIDTH-1:0]      ARADDR,
    input  logic [7:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic [3:0]                   ARREGION,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [AWID_WIDTH-1:0]        RID,
    output logic [WDATA_WIDTH-1:0]       RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         MEM_WE,
    input  logic [$clog2(MEM_DEPTH)-1:0] MEM_WADDR,
    input  logic [WDATA_WIDTH-1:0]       MEM_WDATA
);
    localparam int LB  = $clog2(WDATA_WIDTH / 8);
    localparam int MAW = $clog2(MEM_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;

    logic [WDATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [AWADDR_WIDTH-1:0] addr_q, addr_nxt, lk_addr, step, mask;
    logic [7:0]              len_q, cnt_q;
    logic [2:0]              esz_q, esz_in;
    logic                    fixed_q, wrap_q, wrap_ok, beat_done;
    logic [WDATA_WIDTH-1:0]  rd_data;
    logic [1:0]              rd_resp;

    wire unused_ok = ^{ARREGION, lk_addr};

    always_ff @(posedge ACLK)
        if (MEM_WE) mem[MEM_WADDR] <= MEM_WDATA;

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;

    assign beat_done = RVALID && RREADY && RLAST;

    always_comb begin
        state_nxt = state;
        ARREADY   = 1'b0;
        case (state)
            IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) state_nxt = BURST;
            end
            BURST: if (beat_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign esz_in  = (ARSIZE > 3'(LB)) ? 3'(LB) : ARSIZE;
    assign wrap_ok = (ARBURST == 2'b10) &&
                     (ARLEN == 8'd1 || ARLEN == 8'd3 || ARLEN == 8'd7 || ARLEN == 8'd15);

    // WRAP keeps the bits above the container and lets the offset roll over inside it.
    always_comb begin
        step = AWADDR_WIDTH'(1) << esz_q;
        mask = ((AWADDR_WIDTH'(len_q) + AWADDR_WIDTH'(1)) << esz_q) - AWADDR_WIDTH'(1);
        if (fixed_q)     addr_nxt = addr_q;
        else if (wrap_q) addr_nxt = (addr_q & ~mask) | ((addr_q + step) & mask);
        else             addr_nxt = addr_q + step;
    end

    // One lookup port: the AR address on accept, the next beat address during a burst.
    assign lk_addr = (state == IDLE) ? ARADDR : addr_nxt;

`ifdef AXI_RD_SLAVE_ERR_EN
    logic lk_err;
    assign lk_err  = |lk_addr[AWADDR_WIDTH-1:LB+MAW];
    assign rd_data = lk_err ? '0 : mem[lk_addr[LB +: MAW]];
    assign rd_resp = lk_err ? 2'b10 : 2'b00;
`else
    assign rd_data = mem[lk_addr[LB +: MAW]];
    assign rd_resp = 2'b00;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            esz_q   <= '0;
            fixed_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (state == IDLE) begin
            if (ARVALID) begin
                RID     <= ARID;
                addr_q  <= ARADDR;
                len_q   <= ARLEN;
                esz_q   <= esz_in;
                fixed_q <= (ARBURST == 2'b00);
                wrap_q  <= wrap_ok;
                cnt_q   <= 8'd0;
                RVALID  <= 1'b1;
                RLAST   <= (ARLEN == 8'd0);
                RDATA   <= rd_data;
                RRESP   <= rd_resp;
            end
        end else if (RVALID && RREADY) begin
            if (RLAST) begin
                RVALID <= 1'b0;
                RLAST  <= 1'b0;
            end else begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
                RLAST  <= ((cnt_q + 8'd1) == len_q);
                RDATA  <= rd_data;
                RRESP  <= rd_resp;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: burst-type vectors plus stall, reset and write-hazard sequences.
module tb_axi_rd_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARREGION;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        MEM_WE;
    logic [9:0]  MEM_WADDR;
    logic [63:0] MEM_WDATA;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    axi_rd_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA)
    );

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic [3:0][63:0] d;
        logic [3:0][1:0]  r;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                input logic [1:0] b, input logic [3:0] id,
                                input logic [63:0] d0, d1, d2, d3);
        vec_t v;
        v.addr = a; v.len = l; v.size = s; v.burst = b; v.id = id;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.r = '0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic mem_wr(input int idx, input logic [63:0] data);
        @(negedge ACLK);
        MEM_WE = 1'b1; MEM_WADDR = 10'(idx); MEM_WDATA = data;
        @(negedge ACLK);
        MEM_WE = 1'b0;
    endtask

    task automatic send_ar(input vec_t v, input logic rdy);
        @(negedge ACLK);
        ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size; ARBURST = v.burst;
        ARREGION = 4'h9; ARVALID = 1'b1; RREADY = rdy;
        chk("arready_idle", 64'(ARREADY), 64'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
    endtask

    // RREADY held high: every beat must appear on consecutive cycles after the AR handshake.
    task automatic run_vec(input vec_t v, input string nm);
        send_ar(v, 1'b1);
        for (int b = 0; b <= int'(v.len); b++) begin
            chk({nm, " rvalid"}, 64'(RVALID), 64'd1);
            chk({nm, " rdata"},  RDATA, v.d[b]);
            chk({nm, " rid"},    64'(RID), 64'(v.id));
            chk({nm, " rresp"},  64'(RRESP), 64'(v.r[b]));
            chk({nm, " rlast"},  64'(RLAST), 64'(b == int'(v.len)));
            chk({nm, " arready_busy"}, 64'(ARREADY), 64'd0);
            @(negedge ACLK);
        end
        chk({nm, " rvalid_end"}, 64'(RVALID), 64'd0);
        chk({nm, " arready_end"}, 64'(ARREADY), 64'd1);
    endtask

    vec_t vecs [10];
    vec_t ev;

    initial begin
        vecs[0] = mk(32'h00, 8'd3, 3'd3, 2'b01, 4'd5, 64'h100, 64'h101, 64'h102, 64'h103);
        vecs[1] = mk(32'h10, 8'd3, 3'd3, 2'b10, 4'd2, 64'h102, 64'h103, 64'h100, 64'h101);
        vecs[2] = mk(32'h04, 8'd1, 3'd2, 2'b01, 4'd1, 64'h100, 64'h101, 64'h0,   64'h0);
        vecs[3] = mk(32'h08, 8'd2, 3'd3, 2'b00, 4'd7, 64'h101, 64'h101, 64'h101, 64'h0);
        vecs[4] = mk(32'h07, 8'd1, 3'd0, 2'b01, 4'd3, 64'h100, 64'h101, 64'h0,   64'h0);
        vecs[5] = mk(32'h08, 8'd2, 3'd3, 2'b10, 4'd4, 64'h101, 64'h102, 64'h103, 64'h0);
        vecs[6] = mk(32'h18, 8'd1, 3'd3, 2'b11, 4'd6, 64'h103, 64'h104, 64'h0,   64'h0);
        vecs[7] = mk(32'h38, 8'd1, 3'd3, 2'b10, 4'd8, 64'h107, 64'h106, 64'h0,   64'h0);
        vecs[8] = mk(32'h20, 8'd1, 3'd7, 2'b01, 4'd9, 64'h104, 64'h105, 64'h0,   64'h0);
        vecs[9] = mk(32'h30, 8'd0, 3'd3, 2'b01, 4'hF, 64'h106, 64'h0,   64'h0,   64'h0);

        ARESETn = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        ARREGION = '0; ARVALID = 1'b0; RREADY = 1'b0; MEM_WE = 1'b0; MEM_WADDR = '0; MEM_WDATA = '0;
        repeat (2) @(negedge ACLK);
        chk("rst arready", 64'(ARREADY), 64'd1);
        chk("rst rvalid",  64'(RVALID), 64'd0);
        chk("rst rlast",   64'(RLAST), 64'd0);
        chk("rst rid",     64'(RID), 64'd0);
        chk("rst rdata",   RDATA, 64'd0);
        chk("rst rresp",   64'(RRESP), 64'd0);
        ARESETn = 1'b1;

        for (int i = 0; i < 8; i++) mem_wr(i, 64'h100 + 64'(i));
        mem_wr(1023, 64'h3FF);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // End of memory: second beat either aliases to word 0 or errors out.
        ev = mk(32'((1024 - 1) * 8), 8'd1, 3'd3, 2'b01, 4'hA, 64'h3FF, 64'h100, 64'h0, 64'h0);
`ifdef AXI_RD_SLAVE_ERR_EN
        ev.d[1] = 64'h0;
        ev.r[1] = 2'b10;
`endif
        run_vec(ev, "edge");

        // FIXED with stalls: beat held stable, ARREADY low until after the last handshake.
        send_ar(vecs[3], 1'b0);
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 3; s++) begin
                chk("stall rvalid", 64'(RVALID), 64'd1);
                chk("stall rdata", RDATA, 64'h101);
                chk("stall rid", 64'(RID), 64'd7);
                chk("stall rlast", 64'(RLAST), 64'(b == 2));
                chk("stall arready", 64'(ARREADY), 64'd0);
                RREADY = (s == 2);
                @(negedge ACLK);
            end
            RREADY = 1'b0;
        end
        chk("stall rvalid_end", 64'(RVALID), 64'd0);
        chk("stall arready_end", 64'(ARREADY), 64'd1);

        // Memory writes during a stalled burst.
        send_ar(vecs[0], 1'b0);
        chk("hz beat0", RDATA, 64'h100);
        MEM_WE = 1'b1; MEM_WADDR = 10'd0; MEM_WDATA = 64'hAAA;
        @(negedge ACLK);
        chk("hz beat0 held", RDATA, 64'h100);
        MEM_WADDR = 10'd2; MEM_WDATA = 64'hCCC;
        @(negedge ACLK);
        chk("hz beat0 held2", RDATA, 64'h100);
        MEM_WADDR = 10'd1; MEM_WDATA = 64'hBBB; RREADY = 1'b1;
        @(negedge ACLK);
        MEM_WE = 1'b0;
        chk("hz same-cycle old", RDATA, 64'h101);
        @(negedge ACLK);
        chk("hz later new", RDATA, 64'hCCC);
        @(negedge ACLK);
        chk("hz beat3", RDATA, 64'h103);
        chk("hz rlast", 64'(RLAST), 64'd1);
        @(negedge ACLK);
        chk("hz rvalid_end", 64'(RVALID), 64'd0);
        for (int i = 0; i < 3; i++) mem_wr(i, 64'h100 + 64'(i));

        // Reset during beat 2 of an 8-beat INCR.
        ev = mk(32'h0, 8'd7, 3'd3, 2'b01, 4'hC, 64'h100, 64'h101, 64'h102, 64'h103);
        send_ar(ev, 1'b1);
        chk("rb beat0", RDATA, 64'h100);
        @(negedge ACLK);
        chk("rb beat1", RDATA, 64'h101);
        @(negedge ACLK);
        chk("rb beat2", RDATA, 64'h102);
        ARESETn = 1'b0;
        #1;
        chk("rb rvalid", 64'(RVALID), 64'd0);
        chk("rb arready", 64'(ARREADY), 64'd1);
        chk("rb rlast", 64'(RLAST), 64'd0);
        chk("rb rdata", RDATA, 64'd0);
        chk("rb rid", 64'(RID), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rb dropped", 64'(RVALID), 64'd0);
        run_vec(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
